// File: rtl/ascon_round_sequencer.sv
// Round sequencer for the masked Ascon permutation: constant add, sliced masked
// S-box issue gated by randomness, S-box drain, then linear layer, per round.
module ascon_round_sequencer #(
    parameter int WORD_SIZE = 64,
    parameter int PAR       = 6,
    parameter int D         = 10,
    parameter int SBOX_LAT  = 1,
    localparam int NSLICE   = (WORD_SIZE + PAR - 1) / PAR,
    localparam int LAST_W   = (WORD_SIZE % PAR == 0) ? PAR : WORD_SIZE % PAR,
    localparam int IW       = (NSLICE > 1) ? $clog2(NSLICE) : 1,
    localparam int WW       = $clog2(PAR + 1),
    localparam int OW       = $clog2(WORD_SIZE)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    input  logic [3:0]    nrounds_i,
    input  logic          rng_valid_i,
    output logic          ready_o,
    output logic          done_o,
    output logic [3:0]    round_o,
    output logic [7:0]    rc_o,
    output logic          const_add_o,
    output logic          sbox_en_o,
    output logic          rng_ack_o,
    output logic [IW-1:0] slice_idx_o,
    output logic [OW-1:0] slice_off_o,
    output logic [WW-1:0] slice_width_o,
    output logic          sbox_wb_o,
    output logic [IW-1:0] wb_idx_o,
    output logic          lin_en_o
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CONST = 3'd1;
    localparam logic [2:0] S_SLICE = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_LIN   = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam logic [IW-1:0] LAST_IDX = IW'(NSLICE - 1);

    function automatic logic [WW-1:0] slice_width(input logic [IW-1:0] idx);
        return (idx == LAST_IDX) ? WW'(LAST_W) : WW'(PAR);
    endfunction

    logic [2:0]    r_state;
    logic [3:0]    r_round;
    logic [IW-1:0] r_slice;
    logic          r_wb_vld [SBOX_LAT];
    logic [IW-1:0] r_wb_idx [SBOX_LAT];

    logic          w_in_slice;
    logic          w_issue;
    logic [3:0]    w_nrounds_clamped;
    logic          w_last_wb;
    logic          w_unused_d;

    // Masking order only affects the datapath share count, never the schedule.
    assign w_unused_d = (D < 0);

    assign w_in_slice        = (r_state == S_SLICE);
    assign w_issue           = w_in_slice & rng_valid_i;
    assign w_nrounds_clamped = (nrounds_i > 4'd12) ? 4'd12 : nrounds_i;
    assign w_last_wb         = r_wb_vld[SBOX_LAT-1] && (r_wb_idx[SBOX_LAT-1] == LAST_IDX);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_round <= 4'd0;
            r_slice <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_i && (nrounds_i != 4'd0)) begin
                        r_round <= 4'd12 - w_nrounds_clamped;
                        r_state <= S_CONST;
                    end
                end
                S_CONST: begin
                    r_slice <= '0;
                    r_state <= S_SLICE;
                end
                S_SLICE: begin
                    if (rng_valid_i) begin
                        if (r_slice == LAST_IDX) begin
                            r_state <= S_DRAIN;
                        end else begin
                            r_slice <= r_slice + IW'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_last_wb) begin
                        r_state <= S_LIN;
                    end
                end
                S_LIN: begin
                    if (r_round == 4'd11) begin
                        r_state <= S_DONE;
                    end else begin
                        r_round <= r_round + 4'd1;
                        r_state <= S_CONST;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Write-back pipeline: valid flags are flushed by reset, slice indices are not.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < SBOX_LAT; k++) r_wb_vld[k] <= 1'b0;
        end else begin
            r_wb_vld[0] <= w_issue;
            for (int k = 1; k < SBOX_LAT; k++) r_wb_vld[k] <= r_wb_vld[k-1];
        end
    end

    always_ff @(posedge clk) begin
        r_wb_idx[0] <= r_slice;
        for (int k = 1; k < SBOX_LAT; k++) r_wb_idx[k] <= r_wb_idx[k-1];
    end

    assign ready_o       = (r_state == S_IDLE);
    assign done_o        = (r_state == S_DONE);
    assign const_add_o   = (r_state == S_CONST);
    assign lin_en_o      = (r_state == S_LIN);
    assign sbox_en_o     = w_issue;
    assign rng_ack_o     = w_issue;
    assign round_o       = ready_o ? 4'd0 : r_round;
    assign rc_o          = ready_o ? 8'd0 : {4'd15 - r_round, r_round};
    assign slice_idx_o   = w_in_slice ? r_slice : '0;
    assign slice_off_o   = w_in_slice ? OW'(int'(r_slice) * PAR) : '0;
    assign slice_width_o = w_in_slice ? slice_width(r_slice) : '0;
    assign sbox_wb_o     = r_wb_vld[SBOX_LAT-1];
    assign wb_idx_o      = sbox_wb_o ? r_wb_idx[SBOX_LAT-1] : '0;

endmodule

// File: tb/tb_ascon_round_sequencer.sv
// Bench for ascon_round_sequencer: a per-cycle expected timeline is built from the
// round schedule and the per-cycle randomness pattern, then compared cycle by cycle.
module tb_ascon_round_sequencer;

    localparam int MAXC = 1000;
    localparam int LAT  = 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_i;
    logic [3:0] nrounds_i;
    logic       rng_valid_i;
    logic       ready_o, done_o, const_add_o, sbox_en_o, rng_ack_o, sbox_wb_o, lin_en_o;
    logic [3:0] round_o;
    logic [7:0] rc_o;
    logic [3:0] slice_idx_o;
    logic [5:0] slice_off_o;
    logic [2:0] slice_width_o;
    logic [3:0] wb_idx_o;

    always #5 clk = ~clk;

    ascon_round_sequencer dut (
        .clk(clk), .rst(rst), .start_i(start_i), .nrounds_i(nrounds_i),
        .rng_valid_i(rng_valid_i), .ready_o(ready_o), .done_o(done_o),
        .round_o(round_o), .rc_o(rc_o), .const_add_o(const_add_o),
        .sbox_en_o(sbox_en_o), .rng_ack_o(rng_ack_o), .slice_idx_o(slice_idx_o),
        .slice_off_o(slice_off_o), .slice_width_o(slice_width_o),
        .sbox_wb_o(sbox_wb_o), .wb_idx_o(wb_idx_o), .lin_en_o(lin_en_o)
    );

    int tests = 0;
    int fails = 0;
    int g_cyc = 0;
    int g_done = 0;
    int od;

    int rng     [MAXC];
    int e_ready [MAXC];
    int e_done  [MAXC];
    int e_round [MAXC];
    int e_rc    [MAXC];
    int e_const [MAXC];
    int e_en    [MAXC];
    int e_sidx  [MAXC];
    int e_soff  [MAXC];
    int e_swid  [MAXC];
    int e_wb    [MAXC];
    int e_widx  [MAXC];
    int e_lin   [MAXC];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, g_cyc, obs, exp);
        end
    endtask

    function automatic void set_round(int t, int i);
        e_round[t] = i;
        e_rc[t]    = (15 - i) * 16 + i;
    endfunction

    // Timeline: per round one constant cycle, 11 issues (stalled cycles skipped),
    // LAT drain cycles after the last issue, one linear cycle; then one done cycle.
    function automatic void build(int neff);
        int t, s, i;
        for (int u = 0; u < MAXC; u++) begin
            e_ready[u] = 0; e_done[u] = 0; e_round[u] = 0; e_rc[u] = 0;
            e_const[u] = 0; e_en[u] = 0; e_sidx[u] = 0; e_soff[u] = 0;
            e_swid[u] = 0; e_wb[u] = 0; e_widx[u] = 0; e_lin[u] = 0;
        end
        t = 1;
        for (int r = 0; r < neff; r++) begin
            i = 12 - neff + r;
            set_round(t, i); e_const[t] = 1; t++;
            s = 0;
            while (s < 11 && t < MAXC - 50) begin
                set_round(t, i);
                e_sidx[t] = s;
                e_soff[t] = s * 6;
                e_swid[t] = (s == 10) ? 4 : 6;
                if (rng[t] != 0) begin
                    e_en[t] = 1;
                    e_wb[t + LAT] = 1;
                    e_widx[t + LAT] = s;
                    s++;
                end
                t++;
            end
            for (int k = 0; k < LAT; k++) begin set_round(t, i); t++; end
            set_round(t, i); e_lin[t] = 1; t++;
        end
        set_round(t, 11); e_done[t] = 1; g_done = t;
        for (int u = t + 1; u < MAXC; u++) e_ready[u] = 1;
    endfunction

    function automatic void fill_rng(int random_mode);
        for (int u = 0; u < MAXC; u++)
            rng[u] = (random_mode != 0) ? int'($urandom_range(0, 7) != 0) : 1;
    endfunction

    task automatic chk_cycle(int t);
        chk("ready", 32'(ready_o), e_ready[t]);
        chk("done", 32'(done_o), e_done[t]);
        chk("round", 32'(round_o), e_round[t]);
        chk("rc", 32'(rc_o), e_rc[t]);
        chk("const_add", 32'(const_add_o), e_const[t]);
        chk("sbox_en", 32'(sbox_en_o), e_en[t]);
        chk("rng_ack", 32'(rng_ack_o), e_en[t]);
        chk("slice_idx", 32'(slice_idx_o), e_sidx[t]);
        chk("slice_off", 32'(slice_off_o), e_soff[t]);
        chk("slice_width", 32'(slice_width_o), e_swid[t]);
        chk("sbox_wb", 32'(sbox_wb_o), e_wb[t]);
        chk("wb_idx", 32'(wb_idx_o), e_widx[t]);
        chk("lin_en", 32'(lin_en_o), e_lin[t]);
        chk("excl", 32'($countones({const_add_o, sbox_en_o, lin_en_o}) > 1), 32'd0);
    endtask

    // Idle cycles: optional start with nrounds=0 must be ignored.
    task automatic idle_chk(input int n, input int start_zero);
        for (int k = 0; k < n; k++) begin
            g_cyc = -1 - k;
            rng_valid_i = 1'($urandom_range(0, 1));
            start_i = (start_zero != 0);
            nrounds_i = 4'd0;
            @(negedge clk);
            chk("idle_ready", 32'(ready_o), 32'd1);
            chk("idle_done", 32'(done_o), 32'd0);
            chk("idle_rc", 32'(rc_o), 32'd0);
            chk("idle_round", 32'(round_o), 32'd0);
            chk("idle_strobes", 32'({const_add_o, sbox_en_o, rng_ack_o, sbox_wb_o, lin_en_o}), 32'd0);
            chk("idle_fields", 32'({slice_idx_o, slice_off_o, slice_width_o, wb_idx_o}), 32'd0);
            @(posedge clk); #1;
        end
        start_i = 1'b0;
    endtask

    task automatic run(input logic [3:0] nr, input int neff, input int busy,
                       input int rst_at, output int obs_done);
        build(neff);
        obs_done = -1;
        start_i = 1'b1;
        nrounds_i = nr;
        rng_valid_i = (rng[0] != 0);
        @(posedge clk); #1;
        for (int t = 1; t <= g_done + 1; t++) begin
            g_cyc = t;
            rng_valid_i = (rng[t] != 0);
            start_i = (busy != 0 && t <= g_done) ? 1'($urandom_range(0, 1)) : 1'b0;
            nrounds_i = 4'($urandom_range(0, 15));
            rst = (t == rst_at);
            @(negedge clk);
            chk_cycle(t);
            if (done_o === 1'b1 && obs_done < 0) obs_done = t;
            @(posedge clk); #1;
            if (t == rst_at) begin
                rst = 1'b0;
                break;
            end
        end
        start_i = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        start_i = 1'b0;
        nrounds_i = 4'd0;
        rng_valid_i = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        idle_chk(2, 0);

        fill_rng(0);
        run(4'd12, 12, 0, 0, od);
        chk("done_cycle_12", od, 169);

        run(4'd8, 8, 0, 0, od);
        chk("done_cycle_8", od, 113);

        fill_rng(0);
        rng[7] = 0; rng[8] = 0; rng[9] = 0;
        run(4'd12, 12, 0, 0, od);
        chk("done_cycle_stall", od, 172);

        fill_rng(0);
        run(4'd12, 12, 1, 0, od);
        chk("done_cycle_busy", od, 169);

        idle_chk(6, 1);

        fill_rng(1);
        run(4'd15, 12, 0, 0, od);
        chk("done_cycle_15", od, g_done);

        for (int k = 0; k < 3; k++) begin
            int n;
            n = int'($urandom_range(1, 12));
            fill_rng(1);
            run(4'(n), n, k % 2, 0, od);
            chk("done_cycle_rand", od, g_done);
        end

        fill_rng(0);
        run(4'd12, 12, 0, 50, od);
        idle_chk(20, 0);
        run(4'd12, 12, 0, 0, od);
        chk("done_cycle_after_rst", od, 169);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ascon_round_sequencer.md
# ascon_round_sequencer

Control FSM for the masked Ascon-128a permutation datapath. It runs a requested number of rounds (12 for p^a, 8 for p^b) over the shared 320-bit state. In each round it emits the round constant, streams the five 64-bit lanes through the masked S-box in PAR-bit slices, waits for the S-box pipeline to drain, then fires the linear layer. Slice issue is gated by availability of fresh masking randomness.

## Interface
Parameters:
- WORD_SIZE, 64: lane width in bits.
- PAR, 6: bits per slice processed by the masked S-box per cycle.
- D, 10: masking order; num_shares = D+1 (informational, no effect on timing).
- SBOX_LAT, 1: masked S-box latency in cycles, from issue to write-back; must be ≥1.

Derived values:
- NSLICE = ceil(WORD_SIZE/PAR) = 11.
- LAST_W = (WORD_SIZE%PAR==0) ? PAR : WORD_SIZE%PAR = 4.
- IW = clog2(NSLICE) = 4.
- WW = clog2(PAR+1) = 3.
- OW = clog2(WORD_SIZE) = 6.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start_i  in  1  start request; accepted only when ready_o=1.
- nrounds_i  in  4  round count, sampled with start.
- rng_valid_i  in  1  fresh randomness is available this cycle.
- ready_o  out  1  idle; a start will be accepted.
- done_o  out  1  one-cycle pulse when the permutation completes.
- round_o  out  4  current round constant index i.
- rc_o  out  8  round constant for the current round.
- const_add_o  out  1  XOR rc_o into share 0 of lane x2 this cycle.
- sbox_en_o  out  1  issue one slice to the masked S-box.
- rng_ack_o  out  1  randomness consumed this cycle; equals sbox_en_o.
- slice_idx_o  out  IW  index of the issued slice, 0..NSLICE-1.
- slice_off_o  out  OW  bit offset of the issued slice = slice_idx_o*PAR.
- slice_width_o  out  WW  valid bits in the slice: PAR, or LAST_W for the final slice.
- sbox_wb_o  out  1  S-box result write-back strobe.
- wb_idx_o  out  IW  slice index being written back.
- lin_en_o  out  1  apply the linear diffusion layer this cycle.

## Operation
- FSM states: IDLE, CONST, SLICE, DRAIN, LIN, DONE.
- IDLE:
  - ready_o=1.
  - start_i=1 with 1≤nrounds_i≤12: load round index i = 12-nrounds_i, go to CONST.
  - nrounds_i>12 is clamped to 12.
  - nrounds_i=0: start is ignored and the FSM stays in IDLE.
- CONST:
  - const_add_o=1 for one cycle.
  - rc_o = {4'(15-i), 4'(i)}; rc_o is valid in every non-IDLE state and is 0 in IDLE.
  - Clear the slice counter, go to SLICE.
- SLICE:
  - sbox_en_o = rng_valid_i.
  - On each issue, present the current slice index, offset and width, then increment the counter.
  - rng_valid_i=0 stalls issue: the counter holds and sbox_en_o=0.
  - After slice NSLICE-1 issues, go to DRAIN.
- Write-back pipeline:
  - A SBOX_LAT-deep shift register of {valid, idx}.
  - sbox_wb_o/wb_idx_o appear exactly SBOX_LAT cycles after the matching issue.
  - Write-backs may occur during SLICE.
- DRAIN:
  - Stay until the final write-back cycle has occurred; this lasts SBOX_LAT cycles when there are no stalls.
  - Then go to LIN.
- LIN:
  - lin_en_o=1 for one cycle.
  - If i==11, go to DONE; otherwise i←i+1 and go to CONST.
- DONE:
  - done_o=1 for one cycle, then go to IDLE.
  - ready_o rises in the following cycle.
- start_i outside IDLE is ignored; there is no queueing.
- No two of const_add_o, sbox_en_o and lin_en_o are ever high in the same cycle.
- Reset mid-operation:
  - The next cycle is IDLE with all outputs at their reset values.
  - The write-back pipeline is flushed: no sbox_wb_o after reset.

## Timing
- Reset values:
  - ready_o=1.
  - All other outputs 0, including rc_o, round_o, slice_idx_o, slice_off_o, slice_width_o and wb_idx_o.
- Start is accepted at edge 0; CONST occurs in cycle 1.
- Each round without stalls takes NSLICE+SBOX_LAT+2 cycles (14 with the defaults):
  - CONST: cycle 1.
  - Slices 0..10: cycles 2..12.
  - Write-backs: cycles 3..13.
  - DRAIN: cycle 13.
  - LIN: cycle 14.
- done_o is asserted in cycle nrounds*(NSLICE+SBOX_LAT+2)+1.
- Each cycle with rng_valid_i=0 in SLICE adds exactly one cycle to the total.
- rng_valid_i in other states has no effect.

## Test plan
- Reset: after rst, ready_o=1, rc_o=0, and every strobe (done_o, const_add_o, sbox_en_o, rng_ack_o, sbox_wb_o, lin_en_o) is 0.
- nrounds_i=12, rng_valid_i=1:
  - rc_o=0xF0 with const_add_o in cycle 1.
  - slice_width_o is 6 for slice_idx 0..9 and 4 for slice 10; slice_off_o steps 0,6,…,60.
  - First lin_en_o in cycle 14; the last round has rc_o=0x4B; done_o in cycle 169.
- nrounds_i=8: first rc_o=0xB4, last rc_o=0x4B, done_o in cycle 113.
- rng_valid_i low for 3 cycles while slice 5 is pending:
  - slice_idx_o holds at 5 and no sbox_en_o is issued during the stall.
  - Write-backs stay exactly SBOX_LAT after their issues.
  - done_o moves to cycle 172.
- Start handling:
  - start_i while busy is ignored and completion time is unchanged.
  - nrounds_i=0 leaves ready_o=1 with no activity.
  - nrounds_i=15 behaves exactly like 12.
- Reset mid-run: rst in cycle 50 gives ready_o=1 on the next cycle and no sbox_wb_o or done_o afterwards; a subsequent start runs to done_o in cycle 169.
